// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid buffer: FSM state encoding.
package skid_buffer_pkg;

  localparam int unsigned state_width_lp = 2;

  typedef enum logic [state_width_lp-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/dff.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module dff #(
  parameter int unsigned             width_p     = 1,
  parameter logic [width_p-1:0]      reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      data_o <= reset_val_p;
    else if (en_i)
      data_o <= data_i;
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: full throughput with registered ready_o, v_o and o.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int unsigned        width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [width_p-1:0] i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] o,
  output logic               v_o,
  input  logic               ready_i
);

  skid_state_e        state_r, state_n;
  logic               in_xfer, out_xfer;
  logic               main_en, skid_en;
  logic [width_p-1:0] main_d, skid_q;

  assign in_xfer  = v_i & ready_o;
  assign out_xfer = v_o & ready_i;

  always_comb begin
    state_n = state_r;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = i;
    unique case (state_r)
      EMPTY: begin
        if (in_xfer) begin
          main_en = 1'b1;
          state_n = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          skid_en = 1'b1;
          state_n = TWO;
        end else if (out_xfer) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        // Upstream is stalled here, so the skid entry is the only source for main.
        if (out_xfer) begin
          main_d  = skid_q;
          main_en = 1'b1;
          state_n = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= EMPTY;
      v_o     <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      state_r <= state_n;
      v_o     <= (state_n != EMPTY);
      ready_o <= (state_n != TWO);
    end
  end

  dff #(
    .width_p     (width_p),
    .reset_val_p (reset_val_p)
  ) main_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (main_en),
    .data_i (main_d),
    .data_o (o)
  );

  dff #(
    .width_p     (width_p),
    .reset_val_p (reset_val_p)
  ) skid_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (skid_en),
    .data_i (i),
    .data_o (skid_q)
  );

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: queue-based reference model plus directed literal checks.
module tb_skid_buffer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] i     = '0;
  logic       v_i   = 1'b0;
  logic       ready_i = 1'b0;
  logic       ready_o, v_o;
  logic [7:0] o;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [7:0] q[$];
  bit         started  = 1'b0;
  bit         just_rst = 1'b0;

  skid_buffer #(
    .width_p     (8),
    .reset_val_p (8'h00)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i       (i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .o       (o),
    .v_o     (v_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity two; accept while fewer than two held.
  always @(posedge clk_i) begin
    bit in_x, out_x;
    if (rst_i) begin
      q.delete();
      started  = 1'b1;
      just_rst = 1'b1;
    end else begin
      just_rst = 1'b0;
      in_x  = v_i && (q.size() < 2);
      out_x = (q.size() > 0) && ready_i;
      if (out_x) void'(q.pop_front());
      if (in_x)  q.push_back(i);
    end
  end

  always @(negedge clk_i) begin
    if (started) begin
      chk("v_o", {31'b0, v_o}, {31'b0, q.size() > 0});
      chk("ready_o", {31'b0, ready_o}, {31'b0, q.size() < 2});
      if (q.size() > 0) chk("o", {24'b0, o}, {24'b0, q[0]});
      else if (just_rst) chk("o_after_reset", {24'b0, o}, 32'h0);
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic rs);
    v_i = v; i = d; ready_i = r; rst_i = rs;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset then idle
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_v_o", {31'b0, v_o}, 32'h0);
    chk("rst_ready_o", {31'b0, ready_o}, 32'h1);
    chk("rst_o", {24'b0, o}, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("idle_v_o", {31'b0, v_o}, 32'h0);

    // Streaming 0x01..0x08 at full rate
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, k[7:0], 1'b1, 1'b0);
      chk("stream_o", {24'b0, o}, k);
      chk("stream_ready", {31'b0, ready_o}, 32'h1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_drained", {31'b0, v_o}, 32'h0);

    // Backpressure
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    chk("bp_full_ready", {31'b0, ready_o}, 32'h0);
    chk("bp_full_o", {24'b0, o}, 32'hA1);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    chk("bp_hold_o", {24'b0, o}, 32'hA1);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    chk("bp_drain1", {24'b0, o}, 32'hA2);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    chk("bp_drain2", {24'b0, o}, 32'hA3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_empty", {31'b0, v_o}, 32'h0);

    // Simultaneous enqueue/dequeue in ONE
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b1, 1'b0);
    chk("sim_o", {24'b0, o}, 32'h11);
    chk("sim_v_o", {31'b0, v_o}, 32'h1);
    chk("sim_ready", {31'b0, ready_o}, 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-operation from TWO
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    chk("mid_two_ready", {31'b0, ready_o}, 32'h0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("mid_rst_v_o", {31'b0, v_o}, 32'h0);
    chk("mid_rst_ready", {31'b0, ready_o}, 32'h1);
    chk("mid_rst_o", {24'b0, o}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("mid_no_emit", {31'b0, v_o}, 32'h0);
    end

    // Random valid/ready; upstream holds its offer while stalled
    for (int k = 0; k < 10000; k++) begin
      logic       nv;
      logic [7:0] nd;
      if (v_i && !ready_o) begin
        nv = v_i; nd = i;
      end else begin
        nv = 1'($urandom_range(0, 1));
        nd = 8'($urandom);
      end
      step(nv, nd, 1'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
